// File: rtl/mod_counter_bcd.sv
// Parametrised modulo-N up/down counter with load, cascadable carry/borrow,
// and a sequential shift-add-3 binary-to-BCD converter that follows the count.
module mod_counter_bcd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MODULO = 100,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  o_carry,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = $clog2(WIDTH + 1);
  // One extra bit so MODULO == 2^WIDTH is representable in the load compare
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULO - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  snapshot;
  logic [WIDTH-1:0]  cap_val;
  logic [WIDTH-1:0]  shift_reg;
  logic [BW-1:0]     acc;
  logic [SW-1:0]     step_cnt;

  logic              at_top, at_zero;
  logic [WIDTH-1:0]  load_sat;
  logic              capture, step, finish;
  logic [BW-1:0]     acc_adj;
  logic [BW+WIDTH-1:0] shifted;

  // Terminal-count detection and saturating load value
  always_comb begin
    at_top   = (count == TOP);
    at_zero  = (count == '0);
    load_sat = ({1'b0, load_value} < MOD_EXT) ? load_value : TOP;
    o_carry  = enable & ~clear & ~load &
               ((up_down & at_top) | (~up_down & at_zero));
  end

  // Count register: clear > load > enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_sat;
    end else if (enable) begin
      if (up_down) count <= at_top  ? '0  : count + WIDTH'(1);
      else         count <= at_zero ? TOP : count - WIDTH'(1);
    end
  end

  // Converter state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Converter next-state and step controls
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (count != snapshot) begin
          capture    = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (step_cnt == SW'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One shift-add-3 step: correct digits >= 5, then shift {acc, shift_reg} left
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    shifted = {acc_adj, shift_reg} << 1;
  end

  // Converter datapath; bcd only changes on the final step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      cap_val   <= '0;
      acc       <= '0;
      step_cnt  <= '0;
      snapshot  <= '0;
      bcd       <= '0;
    end else if (capture) begin
      shift_reg <= count;
      cap_val   <= count;
      acc       <= '0;
      step_cnt  <= SW'(WIDTH);
    end else if (step) begin
      shift_reg <= shifted[WIDTH-1:0];
      acc       <= shifted[BW+WIDTH-1:WIDTH];
      step_cnt  <= step_cnt - SW'(1);
      if (finish) begin
        bcd      <= shifted[BW+WIDTH-1:WIDTH];
        snapshot <= cap_val;
      end
    end
  end

  assign bcd_valid = (state == IDLE) && (count == snapshot);

endmodule

// File: tb/tb_mod_counter_bcd.sv
// Directed bench for mod_counter_bcd: counting, carry, load, BCD latency,
// reset mid-conversion, stopwatch cascade and full-range modulus.
module tb_mod_counter_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, up_down, clear, load;
  logic [7:0]  load_value;
  logic [7:0]  count;
  logic        o_carry;
  logic [11:0] bcd;
  logic        bcd_valid;

  logic        c_en;
  logic [7:0]  s_count, m_count;
  logic        s_carry, m_carry;
  logic [11:0] s_bcd, m_bcd;
  logic        s_valid, m_valid;

  logic        f_en, f_up;
  logic [3:0]  f_count;
  logic        f_carry;
  logic [7:0]  f_bcd;
  logic        f_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_counter_bcd #(.WIDTH(8), .MODULO(100), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count(count), .o_carry(o_carry),
    .bcd(bcd), .bcd_valid(bcd_valid));

  mod_counter_bcd #(.WIDTH(8), .MODULO(60), .DIGITS(3)) u_sec (
    .clk(clk), .rst(rst), .enable(c_en), .up_down(1'b1), .clear(1'b0),
    .load(1'b0), .load_value(8'd0), .count(s_count), .o_carry(s_carry),
    .bcd(s_bcd), .bcd_valid(s_valid));

  mod_counter_bcd #(.WIDTH(8), .MODULO(100), .DIGITS(3)) u_min (
    .clk(clk), .rst(rst), .enable(s_carry), .up_down(1'b1), .clear(1'b0),
    .load(1'b0), .load_value(8'd0), .count(m_count), .o_carry(m_carry),
    .bcd(m_bcd), .bcd_valid(m_valid));

  mod_counter_bcd #(.WIDTH(4), .MODULO(16), .DIGITS(2)) u_full (
    .clk(clk), .rst(rst), .enable(f_en), .up_down(f_up), .clear(1'b0),
    .load(1'b0), .load_value(4'd0), .count(f_count), .o_carry(f_carry),
    .bcd(f_bcd), .bcd_valid(f_valid));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input string tag, input int maxc);
    for (int i = 0; i < maxc && !bcd_valid; i++) tick();
    chk(tag, 32'(bcd_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0;
    load_value = 8'd0; c_en = 1'b0; f_en = 1'b0; f_up = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'h000);
    chk("reset_valid", 32'(bcd_valid), 32'd1);

    // Up count through a full wrap
    enable = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("up_count", 32'(count), 32'(i));
      chk("up_carry", 32'(o_carry), (i == 99) ? 32'd1 : 32'd0);
      tick();
    end
    enable = 1'b0;
    chk("up_wrap", 32'(count), 32'd0);
    settle("up_settle", 40);
    chk("up_bcd", 32'(bcd), 32'h000);

    // Down count with borrow from zero
    enable = 1'b1; up_down = 1'b0;
    #1;
    chk("borrow_at_0", 32'(o_carry), 32'd1);
    tick();
    chk("down_99", 32'(count), 32'd99);
    chk("no_borrow_99", 32'(o_carry), 32'd0);
    tick();
    chk("down_98", 32'(count), 32'd98);
    tick();
    chk("down_97", 32'(count), 32'd97);
    enable = 1'b0; up_down = 1'b1;
    settle("down_settle", 40);
    chk("down_bcd", 32'(bcd), 32'h097);

    // Load saturation, load over enable, clear over load
    load = 1'b1; load_value = 8'd250;
    tick();
    chk("load_sat", 32'(count), 32'd99);
    load_value = 8'd42; enable = 1'b1;
    #1;
    chk("load_blocks_carry", 32'(o_carry), 32'd0);
    tick();
    chk("load_42", 32'(count), 32'd42);
    clear = 1'b1; load_value = 8'd10;
    tick();
    chk("clear_wins", 32'(count), 32'd0);
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    settle("load_settle", 40);

    // Latency: 9 invalid cycles after a single step, result on the 10th
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("lat_invalid", 32'(bcd_valid), 32'd0);
      chk("lat_hold", 32'(bcd), 32'h000);
      if (i < 8) tick();
    end
    tick();
    chk("lat_valid", 32'(bcd_valid), 32'd1);
    chk("lat_bcd", 32'(bcd), 32'h001);

    // Second step arrives mid-conversion
    clear = 1'b1;
    tick();
    clear = 1'b0;
    settle("mid_pre_settle", 40);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick(); tick(); tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("mid_first_bcd", 32'(bcd), 32'h001);
    chk("mid_first_invalid", 32'(bcd_valid), 32'd0);
    settle("mid_settle", 13);
    chk("mid_final_bcd", 32'(bcd), 32'h002);

    // Reset during conversion of 57
    load = 1'b1; load_value = 8'd57;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h000);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bcd_valid), 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk("rst_no_stale", 32'(bcd), 32'h000);
      tick();
    end

    // Seconds into minutes cascade: one hour
    c_en = 1'b1;
    for (int i = 0; i < 3600; i++) tick();
    c_en = 1'b0;
    chk("casc_sec", 32'(s_count), 32'd0);
    chk("casc_min", 32'(m_count), 32'd60);
    for (int i = 0; i < 40 && !m_valid; i++) tick();
    chk("casc_min_valid", 32'(m_valid), 32'd1);
    chk("casc_min_bcd", 32'(m_bcd), 32'h060);

    // Full-range modulus wraps at all-ones
    f_en = 1'b1; f_up = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("full_top", 32'(f_count), 32'd15);
    chk("full_carry", 32'(f_carry), 32'd1);
    tick();
    chk("full_wrap", 32'(f_count), 32'd0);
    f_up = 1'b0;
    #1;
    chk("full_borrow", 32'(f_carry), 32'd1);
    tick();
    chk("full_down", 32'(f_count), 32'd15);
    f_en = 1'b0;
    for (int i = 0; i < 30 && !f_valid; i++) tick();
    chk("full_valid", 32'(f_valid), 32'd1);
    chk("full_bcd", 32'(f_bcd), 32'h15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter_bcd.md
Name: mod_counter_bcd

Overview:
- Parametrised modulo-N counter. It generalises the fixed 0-99 minutes counter to any modulus and width.
- Adds up/down counting, synchronous load, and a combinational carry/borrow for same-edge cascading of stopwatch stages (seconds -> minutes -> hours).
- Has an on-board sequential binary-to-BCD converter (shift-add-3) that drives the display digits. The converter tracks the count with bounded latency.

Parameters:
- WIDTH, 8, count register width in bits. Also the number of converter shift cycles.
- MODULO, 100, count range is 0..MODULO-1. Constraint: 2 <= MODULO <= 2^WIDTH.
- DIGITS, 3, number of BCD digits output. Constraint: 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  count enable: advance by one step this cycle (typically the carry of the previous stage).
- up_down  in  1  1 = count up, 0 = count down. Sampled only when a count step occurs.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- o_carry  out  1  combinational terminal-count pulse (carry when up, borrow when down).
- bcd  out  4*DIGITS  registered BCD of the last converted count. Digit 0 is in bits [3:0].
- bcd_valid  out  1  high when bcd corresponds to the current count.

Behaviour:
- Reset (async, while rst=1):
  - count=0, bcd=0, converter IDLE, snapshot register=0.
  - bcd_valid=1 on the first cycle after release.
- Count priority at each rising edge is clear > load > enable.
  - clear: count<=0.
  - load: count<=load_value if load_value<MODULO, else count<=MODULO-1 (saturate).
  - enable with up_down=1: count<=count+1, or 0 when count==MODULO-1.
  - enable with up_down=0: count<=count-1, or MODULO-1 when count==0.
  - None active: hold.
- o_carry is combinational: enable & ~clear & ~load & ((up_down & count==MODULO-1) | (~up_down & count==0)).
  - Asserted in the same cycle the wrap is committed, so a downstream stage using o_carry as its enable steps on the same edge.
  - o_carry is never asserted in a cycle where clear or load wins.
- Converter FSM, states IDLE and CONV:
  - IDLE: if count != snapshot, capture count into the shift register, zero the BCD accumulator, load the step counter with WIDTH, and go to CONV.
  - CONV: each edge performs one step. First add 3 to every BCD digit >=5, then shift {bcd_acc, shift_reg} left by 1. Decrement the step counter.
  - On the edge executing the final (WIDTH-th) step: bcd<=result, snapshot<=captured value, go to IDLE.
- bcd holds its previous value throughout CONV and is never partially updated.
- bcd_valid = (state==IDLE) & (count==snapshot). It is combinational from registered state.
- Latency: count updates at edge k.
  - Capture occurs at edge k+1.
  - The final step occurs at edge k+1+WIDTH.
  - bcd_valid rises in the following cycle, i.e. WIDTH+1 cycles after the count change.
- Count change during CONV: the conversion in progress completes with its captured value.
  - bcd_valid stays 0 throughout.
  - On return to IDLE the mismatch triggers a new conversion.
  - No abort, no queue deeper than one. The final bcd always converges to the latest count once count is stable.
- Count that changes and returns to the same value before capture: no conversion is started.
- rst asserted mid-CONV: FSM to IDLE immediately, with all registers per the reset values above.
- MODULO==2^WIDTH: wrap occurs naturally at all-ones. The comparison logic must not overflow.

Test Plan:
- Reset then 100 enable pulses, WIDTH=8, MODULO=100, up: count 0..99 -> 0. o_carry high only in the cycle count==99. After settling, bcd=12'h000 and bcd_valid=1.
- Cascade two instances, MODULO=60 for seconds into MODULO=100 for minutes. Apply 3600 seconds-enables -> seconds=0, minutes=60, minutes bcd=12'h060.
- Down count from 0 with enable=1, up_down=0: count->99 and o_carry=1 in that cycle. Then 98, 97. bcd settles to 12'h097 after holding.
- Load 8'd250 with MODULO=100 -> count=99. Load 42 with enable=1 in the same cycle -> count=42 and o_carry=0. clear+load together -> count=0.
- Latency check: single enable from count 0 -> bcd_valid low for exactly 9 cycles. bcd=12'h001 on the 10th cycle. Second enable issued mid-conversion -> the first result is written and immediately reconverted. Final bcd=12'h002, bcd_valid=1 within 18 cycles of the second step.
- Assert rst for one cycle mid-CONV with count=57 -> count=0, bcd=0, and bcd_valid=1 the cycle after release, with no stale 12'h057 written.
